// File: rtl/muldiv_sequencer.sv
// ============================================================================
//  Module      : muldiv_sequencer
//  Description : Control sequencer for the multi-cycle MulDiv engine. Decodes
//                MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO requests, latches
//                engine operands, holds engine Start for the whole operation,
//                stalls the issuing stage while busy, and returns MFHI/MFLO
//                data. A watchdog aborts a run whose engine never reports
//                ready.
//                Optional build macro MULDIV_CANCEL_EN adds a 'flush' input
//                that cancels an in-flight operation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_sequencer #(
  parameter int MAX_CYCLES = 40
) (
  input  logic        clk,
  input  logic        reset,
`ifdef MULDIV_CANCEL_EN
  input  logic        flush,
`endif
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        op_ready,
  output logic        stall,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic        busy,
  output logic        timeout_err,
  output logic [31:0] eng_a,
  output logic [31:0] eng_b,
  output logic        eng_mord,
  output logic        eng_start,
  output logic        eng_selhl,
  output logic        eng_write,
  output logic        eng_sign,
  input  logic        eng_ready,
  input  logic [31:0] eng_cout
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_RELEASE = 2'd2,
    S_MFRD    = 2'd3
  } state_t;

  localparam int              c_CW   = $clog2(MAX_CYCLES + 1);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(MAX_CYCLES - 1);

  state_t          r_state;
  logic [c_CW-1:0] r_cnt;
  logic [31:0]     r_a;
  logic [31:0]     r_b;
  logic            r_mord;
  logic            r_sign;
  logic            r_start;
  logic            r_selhl;
  logic            r_write;
  logic            r_res_valid;
  logic [31:0]     r_res_data;
  logic            r_timeout;

  logic            w_flush;
  logic            w_idle;
  logic            w_is_md;
  logic            w_is_mf;
  logic            w_is_mt;
  logic            w_mf_sel;
  logic            w_mf_conflict;
  logic            w_ready;
  logic            w_accept;

`ifdef MULDIV_CANCEL_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // Request decode: bit 2 clear is the MUL/DIV class, 10x is MF, 11x is MT.
  assign w_is_md  = ~op_code[2];
  assign w_is_mf  = (op_code[2:1] == 2'b10);
  assign w_is_mt  = (op_code[2:1] == 2'b11);
  assign w_mf_sel = ~op_code[0];
  assign w_idle   = (r_state == S_IDLE);

  // The engine select is shared between an MT write pulse and an MF read in
  // the same cycle. When both target the same register the written value is
  // forwarded; when they target different registers the MF waits one cycle
  // for the write pulse to finish.
  assign w_mf_conflict = r_write & w_is_mf & (w_mf_sel != r_selhl);

  assign w_ready  = w_idle & ~w_flush & ~(op_valid & w_mf_conflict);
  assign w_accept = op_valid & w_ready;

  assign op_ready    = w_ready;
  assign stall       = op_valid & ~w_ready;
  assign busy        = ~w_idle;
  assign res_valid   = r_res_valid;
  assign res_data    = r_res_data;
  assign timeout_err = r_timeout;
  assign eng_a       = r_a;
  assign eng_b       = r_b;
  assign eng_mord    = r_mord;
  assign eng_sign    = r_sign;
  assign eng_start   = r_start;
  assign eng_write   = r_write;
  // MF drives the select combinationally in its accept cycle; otherwise the
  // select follows the last MT target.
  assign eng_selhl   = (w_accept & w_is_mf) ? w_mf_sel : r_selhl;

  // Sequencer state machine with registered engine controls and watchdog.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_mord      <= 1'b0;
      r_sign      <= 1'b0;
      r_start     <= 1'b0;
      r_selhl     <= 1'b0;
      r_write     <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_write     <= 1'b0;
      r_res_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_md) begin
              // Operands stay frozen until IDLE: the engine re-reads them in
              // its final sign-correction step.
              r_a     <= op_a;
              r_b     <= op_b;
              r_mord  <= op_code[1];
              r_sign  <= ~op_code[0];
              r_start <= 1'b1;
              r_cnt   <= '0;
              r_state <= S_RUN;
            end else if (w_is_mf) begin
              r_res_data  <= r_write ? r_a : eng_cout;
              r_res_valid <= 1'b1;
              r_state     <= S_MFRD;
            end else if (w_is_mt) begin
              r_a     <= op_a;
              r_selhl <= ~op_code[0];
              r_write <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_flush) begin
            r_start <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else if ((r_cnt != '0) && eng_ready) begin
            // The first RUN cycle is skipped: the engine's ready is stale then.
            r_start <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_RELEASE;
          end else if (r_cnt == c_LAST) begin
            r_timeout <= 1'b1;
            r_start   <= 1'b0;
            r_cnt     <= '0;
            r_state   <= S_RELEASE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RELEASE: begin
          // One cycle with Start low lets the engine clear its step counter.
          r_start <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        S_MFRD: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_start <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
